// File: rtl/inst_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction BRAM read port, redirect input and the
// valid/ready instruction stream (with pre-split decode fields) towards decode.
interface inst_fetch_stage_if #(
  parameter int unsigned IMEM_ADDR_W = 14
);
  logic                   imem_en;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [31:0]            imem_rdata;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_pc;
  logic [31:0]            out_instr;
  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic [6:0]             funct7;

  modport master (
    output imem_en,
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output opcode,
    output funct3,
    output funct7
  );

  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  opcode,
    input  funct3,
    input  funct7
  );
endinterface

// File: rtl/inst_fetch_stage.sv
// Instruction fetch: PC owner, 1-cycle-latency BRAM reader, 2-entry output queue.
// Define FETCH_STATS_EN to add the stat_fetched/stat_stall/stat_flush counters.
module inst_fetch_stage #(
  parameter int unsigned IMEM_ADDR_W = 14,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rstn,
  inst_fetch_stage_if.master  bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]         stat_fetched,
  output logic [31:0]         stat_stall,
  output logic [15:0]         stat_flush
`endif
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                 state_q;
  state_e                 state_d;

  logic [31:0]            fetch_pc;
  logic [31:0]            inflight_pc;
  logic                   inflight;

  logic [31:0]            q_pc    [2];
  logic [31:0]            q_instr [2];
  logic                   rd_ptr;
  logic                   wr_ptr;
  logic [1:0]             count;

  logic                   running;
  logic                   flush;
  logic                   pop;
  logic                   push;
  logic                   issue;
  logic [2:0]             occupancy;
  logic [31:0]            redirect_base;
  logic [31:0]            issue_pc;
  logic [IMEM_ADDR_W-1:0] addr_d;

  assign running       = (state_q == RUN);
  assign flush         = running && bus.redirect_valid;
  assign redirect_base = {bus.redirect_pc[31:2], 2'b00};
  assign issue_pc      = flush ? redirect_base : fetch_pc;
  assign occupancy     = {1'b0, count} + {2'b00, inflight};
  assign pop           = bus.out_valid && bus.out_ready;
  // A redirect squashes the word returning this cycle: it belongs to the old stream.
  assign push          = inflight && !flush;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // ---------------- FSM: outputs (BRAM request) ----------------
  always_comb begin
    issue  = 1'b0;
    addr_d = fetch_pc[IMEM_ADDR_W+1:2];
    unique case (state_q)
      BOOT: issue = 1'b0;
      RUN: begin
        // Occupancy never exceeds 2, so a pop is what frees the slot at the limit.
        issue  = flush || (occupancy < 3'd2) || ((occupancy == 3'd2) && pop);
        addr_d = issue_pc[IMEM_ADDR_W+1:2];
      end
      default: issue = 1'b0;
    endcase
  end

  assign bus.imem_en   = issue;
  assign bus.imem_addr = addr_d;

  // ---------------- PC and in-flight tracking ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= issue_pc;
        fetch_pc    <= issue_pc + 32'd4;
      end
    end
  end

  // ---------------- 2-entry output queue ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        q_pc[wr_ptr]    <= inflight_pc;
        q_instr[wr_ptr] <= bus.imem_rdata;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.out_valid = (count != 2'd0);
  assign bus.out_pc    = q_pc[rd_ptr];
  assign bus.out_instr = q_instr[rd_ptr];
  assign bus.opcode    = q_instr[rd_ptr][6:0];
  assign bus.funct3    = q_instr[rd_ptr][14:12];
  assign bus.funct7    = q_instr[rd_ptr][31:25];

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_fetched <= '0;
      stat_stall   <= '0;
      stat_flush   <= '0;
    end else begin
      if (pop) begin
        stat_fetched <= stat_fetched + 32'd1;
      end
      if (bus.out_valid && !bus.out_ready) begin
        stat_stall <= stat_stall + 32'd1;
      end
      if (bus.redirect_valid) begin
        stat_flush <= stat_flush + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: directed scenarios plus random ready/redirect
// traffic, checked against a queue-based reference model of the fetch rules.
module tb_inst_fetch_stage;
  localparam int unsigned AW     = 14;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_stage_if #(.IMEM_ADDR_W(AW)) bus ();

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_stall;
  logic [15:0] stat_flush;
`endif

  inst_fetch_stage #(
    .IMEM_ADDR_W(AW),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
`ifdef FETCH_STATS_EN
    .stat_fetched(stat_fetched),
    .stat_stall  (stat_stall),
    .stat_flush  (stat_flush),
`endif
    .bus         (bus)
  );

  // Synchronous BRAM, 1-cycle read latency
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] bram_q;
  always @(posedge clk) if (bus.imem_en) bram_q <= mem[bus.imem_addr];
  assign bus.imem_rdata = bram_q;

  // Reference model state
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  bit          m_run;
  bit          m_pend;
  logic [31:0] m_pc;
  logic [31:0] m_pend_pc;
  logic [31:0] s_fetched;
  logic [31:0] s_stall;
  logic [15:0] s_flush;

  int checks = 0;
  int errors = 0;

  logic [31:0] dpc [13] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'h8,
                             32'h8, 32'h8, 32'h8, 32'h8, 32'hC, 32'h10};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return mem[pc[AW+1:2]];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_run     = 1'b0;
    m_pend    = 1'b0;
    m_pc      = RST_PC;
    m_pend_pc = '0;
    s_fetched = '0;
    s_stall   = '0;
    s_flush   = '0;
  endtask

  // Drive one cycle's inputs, check outputs against the model, then advance the model.
  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
    int unsigned occ;
    bit          ev, pop, een, fl;
    logic [31:0] ipc;
    ent_t        h;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
    fl  = m_run && rv;
    ipc = fl ? {rpc[31:2], 2'b00} : m_pc;
    occ = mq.size() + 32'(m_pend);
    ev  = (mq.size() != 0);
    pop = ev && rdy;
    een = m_run && (fl || occ < 2 || (occ == 2 && pop));
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("imem_en", 32'(bus.imem_en), 32'(een));
    if (een) chk("imem_addr", 32'(bus.imem_addr), 32'(ipc[AW+1:2]));
    if (ev) begin
      h = mq[0];
      chk("out_pc", bus.out_pc, h.pc);
      chk("out_instr", bus.out_instr, h.instr);
      chk("opcode", 32'(bus.opcode), 32'(h.instr[6:0]));
      chk("funct3", 32'(bus.funct3), 32'(h.instr[14:12]));
      chk("funct7", 32'(bus.funct7), 32'(h.instr[31:25]));
    end
`ifdef FETCH_STATS_EN
    chk("stat_fetched", stat_fetched, s_fetched);
    chk("stat_stall", stat_stall, s_stall);
    chk("stat_flush", 32'(stat_flush), 32'(s_flush));
`endif
    if (pop) s_fetched = s_fetched + 32'd1;
    if (ev && !rdy) s_stall = s_stall + 32'd1;
    if (rv) s_flush = s_flush + 16'd1;
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_pend) mq.push_back('{pc: m_pend_pc, instr: word_at(m_pend_pc)});
    end
    m_pend = een;
    if (een) begin
      m_pend_pc = ipc;
      m_pc      = ipc + 32'd4;
    end
    m_run = 1'b1;
  endtask

  task automatic cyc(input bit rdy, input bit rv, input logic [31:0] rpc);
    @(negedge clk);
    step(rdy, rv, rpc);
  endtask

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_imem_en"}, 32'(bus.imem_en), 32'd0);
    chk({tag, "_out_pc"}, bus.out_pc, 32'd0);
    chk({tag, "_out_instr"}, bus.out_instr, 32'd0);
    chk({tag, "_opcode"}, 32'(bus.opcode), 32'd0);
    chk({tag, "_funct3"}, 32'(bus.funct3), 32'd0);
    chk({tag, "_funct7"}, 32'(bus.funct7), 32'd0);
`ifdef FETCH_STATS_EN
    chk({tag, "_stat_fetched"}, stat_fetched, 32'd0);
    chk({tag, "_stat_stall"}, stat_stall, 32'd0);
    chk({tag, "_stat_flush"}, 32'(stat_flush), 32'd0);
`endif
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    mem[32'h1000 >> 2] = 32'h00A2_8293;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // Release and stream 0,4,8; then stall 5 cycles with pc 8 at the head
    rstn = 1'b1;
    step(1'b1, 1'b0, '0);
    chk("boot_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 1; i <= 12; i++) begin
      cyc(i < 5 || i > 9, 1'b0, '0);
      if (i < 3) begin
        chk("first_latency", 32'(bus.out_valid), 32'd0);
      end else begin
        chk("seq_valid", 32'(bus.out_valid), 32'd1);
        chk("seq_pc", bus.out_pc, dpc[i]);
        chk("seq_instr", bus.out_instr, word_at(dpc[i]));
      end
      if (i >= 7 && i <= 9) chk("stall_no_issue", 32'(bus.imem_en), 32'd0);
    end

    // Fill the queue, then redirect to 0x100
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 32'h100);
    chk("redir_en", 32'(bus.imem_en), 32'd1);
    chk("redir_addr", 32'(bus.imem_addr), 32'h40);
    cyc(1'b1, 1'b0, '0);
    chk("redir_bubble", 32'(bus.out_valid), 32'd0);
    cyc(1'b1, 1'b0, '0);
    chk("redir_valid", 32'(bus.out_valid), 32'd1);
    chk("redir_pc", bus.out_pc, 32'h100);

    // Back-to-back redirects: only the later stream survives
    cyc(1'b1, 1'b1, 32'h200);
    cyc(1'b1, 1'b1, 32'h300);
    cyc(1'b1, 1'b0, '0);
    chk("b2b_bubble", 32'(bus.out_valid), 32'd0);
    cyc(1'b1, 1'b0, '0);
    chk("b2b_pc0", bus.out_pc, 32'h300);
    cyc(1'b1, 1'b0, '0);
    chk("b2b_pc1", bus.out_pc, 32'h304);

    // Field split of addi x5,x5,10
    cyc(1'b1, 1'b1, 32'h1000);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    chk("dec_instr", bus.out_instr, 32'h00A2_8293);
    chk("dec_opcode", 32'(bus.opcode), 32'h13);
    chk("dec_funct3", 32'(bus.funct3), 32'h0);
    chk("dec_funct7", 32'(bus.funct7), 32'h0);

    // PC wrap (low redirect bits ignored)
    cyc(1'b1, 1'b1, 32'hFFFF_FFFD);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    chk("wrap_pc0", bus.out_pc, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, '0);
    chk("wrap_pc1", bus.out_pc, 32'h0);

    rand_cycles(3000);

    // Asynchronous reset mid-stream
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    #1 rstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    step(1'b1, 1'b0, '0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 1'b0, '0);
      if (i == 3) chk("restart_pc0", bus.out_pc, RST_PC);
      if (i == 4) chk("restart_pc1", bus.out_pc, RST_PC + 32'd4);
    end

    rand_cycles(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
